rom_fetch_unit: RTL and testbench
=================================

ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 15'h0000, byte address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, prefetch buffer entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 fetch_en  input  1  high = fetching permitted; low = no new rom_req issued.
REQ-006 redirect_valid  input  1  one-cycle pulse: flush buffer, restart fetch at redirect_pc.
REQ-007 redirect_pc  input  15  new fetch byte address.
REQ-008 rom_req  output  1  ROM read request, one cycle per word.
REQ-009 rom_addr  output  15  ROM byte address, valid while rom_req=1.
REQ-010 rom_rdata  input  32  ROM read data, valid while rom_ready=1.
REQ-011 rom_ready  input  1  ROM response strobe, exactly one cycle after each rom_req.
REQ-012 instr_valid  output  1  buffer head holds a valid instruction.
REQ-013 instr_data  output  32  instruction word at buffer head.
REQ-014 instr_pc  output  15  byte address of instr_data.
REQ-015 instr_ready  input  1  consumer accepts head when instr_valid=1.
REQ-016 fetch_err  output  1  sticky misaligned-redirect error (present only with FETCH_ALIGN_CHECK_EN).

Function
REQ-017 States: IDLE (no issue), RUN (issuing), DISCARD (drop one stale response); reset state IDLE.
REQ-018 IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0 (in-flight response still captured); RUN->DISCARD on redirect with a request in flight; DISCARD->RUN after the stale rom_ready cycle.
REQ-019 rom_req=1 in RUN only when occupancy + in-flight count < FIFO_DEPTH; at most one request per cycle, back-to-back allowed.
REQ-020 rom_addr = fetch PC; fetch PC += 4 per issued request, wraps 15'h7FFC -> 15'h0000.
REQ-021 On rom_ready (not DISCARD) {rom_rdata, issued address} pushed into buffer; instr_valid rises next cycle: rom_req cycle N -> rom_ready N+1 -> instr_valid N+2.
REQ-022 Sustained throughput one instruction per cycle with instr_ready held high.
REQ-023 Pop when instr_valid & instr_ready; push and pop same cycle leaves occupancy unchanged.
REQ-024 Buffer full: no rom_req issued; buffer never overflows; rom_ready with no credit is a protocol violation (assertion).
REQ-025 Buffer empty: instr_valid=0; instr_data/instr_pc hold last values.
REQ-026 redirect_valid has priority over all events: buffer cleared, fetch PC = redirect_pc, same-cycle pop/push discarded, new rom_req no earlier than next cycle.
REQ-027 Redirect during DISCARD: fetch PC updated; still exactly one stale response dropped.
REQ-028 Redirect while fetch_en=0: fetch PC updated, stays IDLE.

Reset
REQ-029 Async assert: state IDLE, rom_req=0, rom_addr=RESET_PC, fetch PC=RESET_PC, buffer empty, instr_valid=0, instr_data=0, instr_pc=0, fetch_err=0, in-flight cleared.
REQ-030 Reset mid-fetch: in-flight response abandoned; rom_ready in first cycle after release ignored.
REQ-031 First rom_req no earlier than first rising edge after deassertion with fetch_en=1.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fetch_err (sticky until reset), clears buffer, forces IDLE; no fetch until an aligned redirect; fetch_err port present.
REQ-033 Macro undefined: redirect_pc[1:0] ignored (treated as 2'b00), fetch_err port absent, no error state.

Verification
REQ-034 Reset, fetch_en=1, ROM word i = 32'hDEAD_0000+i, instr_ready=1 -> instr_pc 0,4,8,... data DEAD0000, DEAD0001,... first instr_valid 2 cycles after first rom_req, one per cycle after.
REQ-035 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) requests issued, rom_req then 0, no data lost on resume.
REQ-036 Redirect to 15'h0100 with request in flight -> stale word dropped; next instr_pc=0x0100, data DEAD0040.
REQ-037 Redirect to 15'h7FF8 -> instr_pc 7FF8, 7FFC, 0000, 0004 in order.
REQ-038 fetch_en=0 mid-stream -> no rom_req after that cycle, in-flight word still delivered; fetch_en=1 resumes at next sequential address.
REQ-039 FETCH_ALIGN_CHECK_EN defined, redirect to 15'h0102 -> fetch_err=1, no rom_req; aligned redirect to 15'h0000 -> fetching resumes, fetch_err stays 1 until reset.

Source files
------------

// File: rtl/rom_fetch_unit.sv
// Instruction prefetch unit: issues sequential ROM word reads into a small
// buffer, handles redirects. Optional misaligned-redirect check: FETCH_ALIGN_CHECK_EN.
module rom_fetch_unit #(
  parameter logic [14:0] RESET_PC   = 15'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [14:0] redirect_pc,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [14:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  // state     | meaning
  // S_IDLE    | no requests issued
  // S_RUN     | issuing requests while buffer credit allows
  // S_DISCARD | dropping the response of a request issued in the redirect cycle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DISCARD} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [14:0]   r_pc;
  logic          r_inflight;
  logic [14:0]   r_req_addr;
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [14:0]   r_mem_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_last_data;
  logic [14:0]   r_last_pc;

  logic [14:0]   w_redir_pc;
  logic [CW-1:0] w_occ;
  logic          w_credit;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_misalign;
  logic          w_halted;
  logic          w_err_drop;

  assign w_redir_pc = redirect_pc & 15'h7FFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;
  logic r_halt;
  logic r_drop;

  assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign w_halted   = r_halt;
  assign w_err_drop = r_drop;
  assign fetch_err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_halt <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_misalign & rom_req;
      if (w_misalign) begin
        r_err  <= 1'b1;
        r_halt <= 1'b1;
      end else if (redirect_valid) begin
        r_halt <= 1'b0;
      end
    end
  end
`else
  assign w_misalign = 1'b0;
  assign w_halted   = 1'b0;
  assign w_err_drop = 1'b0;
`endif

  // Credit counts the slot freed by a same-cycle pop so streaming reaches one word per cycle.
  assign instr_valid = (r_count != '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_occ       = r_count + CW'(r_inflight) - CW'(instr_valid & instr_ready);
  assign w_credit    = (w_occ < CW'(FIFO_DEPTH));
  assign w_push      = rom_ready & r_inflight & ~redirect_valid & ~w_err_drop
                       & (r_state != S_DISCARD);
  assign w_pop       = instr_valid & instr_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (fetch_en && !w_halted) w_state_nxt = S_RUN;
      S_RUN: begin
        if (redirect_valid && rom_req) w_state_nxt = S_DISCARD;
        else if (!fetch_en)            w_state_nxt = S_IDLE;
      end
      S_DISCARD: w_state_nxt = S_RUN;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_misalign) w_state_nxt = S_IDLE;
  end

  always_comb begin
    rom_req  = (r_state == S_RUN) & fetch_en & w_credit;
    rom_addr = r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_addr <= '0;
    end else begin
      r_inflight <= rom_req;
      if (rom_req) r_req_addr <= rom_addr;
      if (redirect_valid) r_pc <= w_redir_pc;
      else if (rom_req)   r_pc <= r_pc + 15'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_rdata;
      r_mem_pc[r_wr_ptr]   <= r_req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_last_data <= '0;
      r_last_pc   <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_last_data <= r_mem_data[r_rd_ptr];
        r_last_pc   <= r_mem_pc[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Empty buffer presents the most recently consumed word.
  assign instr_data = instr_valid ? r_mem_data[r_rd_ptr] : r_last_data;
  assign instr_pc   = instr_valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit with a one-cycle-latency ROM responder.
module tb_rom_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        rom_ready;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [14:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cnt = 0;
  int first_req = -1;
  int first_valid = -1;
  int n0, s0, s1;
  logic [14:0] q_pc[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  rom_fetch_unit #(.RESET_PC(15'h0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rom_ready(rom_ready), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_err(fetch_err)
`endif
  );

  always #5 clk = ~clk;

  // ROM: word at byte address A holds DEAD_0000 + A/4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ready <= 1'b0;
      rom_rdata <= '0;
    end else begin
      rom_ready <= rom_req;
      rom_rdata <= 32'hDEAD_0000 + {19'd0, rom_addr[14:2]};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
      end
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && instr_ready && !redirect_valid) begin
        q_pc.push_back(instr_pc);
        q_data.push_back(instr_data);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    #2;
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_err", 32'(fetch_err), 32'd0);
`endif
    tick(3);
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    #1;
    chk("idle_no_req", 32'(rom_req), 32'd0);
    tick(10);

    // sequential stream
    chk("stream_cnt", 32'(q_pc.size() >= 4), 32'd1);
    chk("latency", 32'(first_valid - first_req), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", 32'(q_pc[i]), 32'(4 * i));
      chk("stream_data", q_data[i], 32'hDEAD_0000 + 32'(i));
    end
    chk("stream_rate", 32'(q_cyc[3] - q_cyc[0]), 32'd3);

    // fetch_en low: in-flight word still delivered, nothing new issued
    fetch_en = 1'b0;
    #1;
    chk("stop_req", 32'(rom_req), 32'd0);
    tick(6);
    n0 = req_cnt;
    chk("stop_all_delivered", 32'(q_pc.size()), 32'(n0));
    chk("stop_last_pc", 32'(q_pc[q_pc.size() - 1]), 32'(4 * (n0 - 1)));
    chk("stop_last_data", q_data[q_data.size() - 1], 32'hDEAD_0000 + 32'(n0 - 1));

    // resume with consumer stalled: exactly two requests fill the buffer
    s0 = q_pc.size();
    fetch_en = 1'b1; instr_ready = 1'b0;
    tick(10);
    chk("stall_reqs", 32'(req_cnt - n0), 32'd2);
    chk("stall_req_low", 32'(rom_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_head_pc", 32'(instr_pc), 32'(4 * n0));
    chk("stall_no_pop", 32'(q_pc.size()), 32'(s0));
    instr_ready = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      chk("resume_pc", 32'(q_pc[s0 + i]), 32'(4 * (n0 + i)));
      chk("resume_data", q_data[s0 + i], 32'hDEAD_0000 + 32'(n0 + i));
    end

    // redirect with a request in flight
    tick(2);
    chk("redir_inflight", 32'(rom_req), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 15'h0100;
    s0 = q_pc.size();
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    chk("redir_pc0", 32'(q_pc[s0]), 32'h0100);
    chk("redir_data0", q_data[s0], 32'hDEAD_0040);
    chk("redir_pc1", 32'(q_pc[s0 + 1]), 32'h0104);

    // address wrap
    redirect_valid = 1'b1; redirect_pc = 15'h7FF8;
    s0 = q_pc.size();
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    chk("wrap_pc0", 32'(q_pc[s0]), 32'h7FF8);
    chk("wrap_pc1", 32'(q_pc[s0 + 1]), 32'h7FFC);
    chk("wrap_pc2", 32'(q_pc[s0 + 2]), 32'h0000);
    chk("wrap_pc3", 32'(q_pc[s0 + 3]), 32'h0004);
    chk("wrap_data0", q_data[s0], 32'hDEAD_1FFE);
    chk("wrap_data1", q_data[s0 + 1], 32'hDEAD_1FFF);
    chk("wrap_data2", q_data[s0 + 2], 32'hDEAD_0000);
    chk("wrap_data3", q_data[s0 + 3], 32'hDEAD_0001);

    // redirect while idle
    fetch_en = 1'b0;
    tick(5);
    n0 = req_cnt;
    redirect_valid = 1'b1; redirect_pc = 15'h0200;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    chk("idle_redir_noreq", 32'(req_cnt), 32'(n0));
    chk("idle_redir_addr", 32'(rom_addr), 32'h0200);
    chk("idle_redir_valid", 32'(instr_valid), 32'd0);
    s0 = q_pc.size();
    fetch_en = 1'b1;
    tick(6);
    chk("idle_resume_pc", 32'(q_pc[s0]), 32'h0200);
    chk("idle_resume_data", q_data[s0], 32'hDEAD_0080);

    // reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_req", 32'(rom_req), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_pc", 32'(instr_pc), 32'd0);
    chk("mid_rst_data", instr_data, 32'd0);
    tick(2);
    s0 = q_pc.size();
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_pc", 32'(q_pc[s0]), 32'h0000);
    chk("post_rst_data", q_data[s0], 32'hDEAD_0000);

`ifdef FETCH_ALIGN_CHECK_EN
    // misaligned redirect halts fetch; aligned redirect resumes
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 15'h0102;
    s1 = q_pc.size();
    tick(1);
    redirect_valid = 1'b0;
    chk("align_err_set", 32'(fetch_err), 32'd1);
    tick(3);
    n0 = req_cnt;
    tick(4);
    chk("align_no_req", 32'(req_cnt), 32'(n0));
    chk("align_req_low", 32'(rom_req), 32'd0);
    chk("align_no_data", 32'(q_pc.size()), 32'(s1));
    s0 = q_pc.size();
    redirect_valid = 1'b1; redirect_pc = 15'h0000;
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    chk("align_resume_pc", 32'(q_pc[s0]), 32'h0000);
    chk("align_resume_data", q_data[s0], 32'hDEAD_0000);
    chk("align_err_sticky", 32'(fetch_err), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
